// File: rtl/mem_sram_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM controller.
// Holds the FSM encoding, the SRAM address/data widths, the wait-counter width
// and the captured-request record. A helper builds the 18-bit halfword address.
package mem_sram_ctrl_pkg;

  localparam int unsigned StateW = 2;
  localparam int unsigned SramAw = 18;
  localparam int unsigned SramDw = 16;
  localparam int unsigned CntW   = 3;
  // Word index within the SRAM: the low halfword-select bit is added per phase.
  localparam int unsigned HaddrW = SramAw - 1;

  typedef logic [StateW-1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StLo   = 2'd1;
  localparam state_t StHi   = 2'd2;
  localparam state_t StDone = 2'd3;

  // Everything latched from the MEM stage when an access starts.
  typedef struct packed {
    logic              we;
    logic [HaddrW-1:0] haddr;
    logic [31:0]       wdata;
  } acc_t;

  function automatic logic [SramAw-1:0] half_addr(input logic [HaddrW-1:0] haddr,
                                                  input logic              hi);
    return {haddr, hi};
  endfunction

endpackage

// File: rtl/mem_sram_ctrl.sv
// MEM-stage controller for a 16-bit asynchronous SRAM.
// Each 32-bit load/store is split into a low and a high halfword phase, each
// held for WAIT_CYCLES+1 cycles, followed by a one-cycle DONE with ready=1.
// Ports:
//   clk, rst (async, active-low)
//   MEM_R, MEM_W, addr, wdata  - request from the MEM stage, held until ready
//   rdata, ready, freeze       - load data, completion pulse, pipeline stall
//   sram_addr, sram_we_n, sram_dq_out, sram_dq_oe, sram_dq_in - SRAM pins
module mem_sram_ctrl
  import mem_sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_R,
  input  logic              MEM_W,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              freeze,
  output logic [SramAw-1:0] sram_addr,
  output logic              sram_we_n,
  output logic [SramDw-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [SramDw-1:0] sram_dq_in
);

  localparam logic [CntW-1:0] LastCnt = CntW'(WAIT_CYCLES);

  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  acc_t              acc_q, acc_d;
  logic [SramDw-1:0] lo_q, lo_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q;
  logic              req;
  logic              last;
  logic              in_phase;

  // Only the word index addr[18:2] reaches the SRAM; the rest is don't-care.
  logic unused_addr;
  assign unused_addr = ^{addr[31:19], addr[1:0]};

  assign req      = MEM_R | MEM_W;
  assign last     = (cnt_q == LastCnt);
  assign in_phase = (state_q == StLo) || (state_q == StHi);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    rdata_d = rdata_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          state_d     = StLo;
          cnt_d       = '0;
          acc_d.we    = MEM_W;  // a store wins over a simultaneous load
          acc_d.haddr = addr[18:2];
          acc_d.wdata = wdata;
        end
      end
      StLo: begin
        if (last) begin
          state_d = StHi;
          cnt_d   = '0;
          // Low half is parked so rdata only changes once the whole word is in.
          if (!acc_q.we) lo_d = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHi: begin
        if (last) begin
          state_d = StDone;
          cnt_d   = '0;
          if (!acc_q.we) rdata_d = {sram_dq_in, lo_q};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
      ready_q <= (state_d == StDone);
    end
  end

  // SRAM pins are a pure decode of the registered state, so reset forces them
  // idle immediately and an abandoned write drops we_n at once.
  always_comb begin
    sram_addr   = '0;
    sram_we_n   = 1'b1;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    if (in_phase) begin
      sram_addr = half_addr(acc_q.haddr, state_q == StHi);
      if (acc_q.we) begin
        sram_we_n   = 1'b0;
        sram_dq_oe  = 1'b1;
        sram_dq_out = (state_q == StHi) ? acc_q.wdata[31:16] : acc_q.wdata[15:0];
      end
    end
  end

  assign rdata  = rdata_q;
  assign ready  = ready_q;
  assign freeze = req & ~ready_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Bench for mem_sram_ctrl: instance 0 uses WAIT_CYCLES=0, instance 1 the
// default of 1. A cycle-count model per instance predicts every output each
// cycle; directed sequences add literal expectations.
module tb_mem_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst     [2];
  logic        mem_r   [2];
  logic        mem_w   [2];
  logic [31:0] addr    [2];
  logic [31:0] wdata   [2];
  logic [31:0] rdata   [2];
  logic        ready   [2];
  logic        freeze  [2];
  logic [17:0] s_addr  [2];
  logic        we_n    [2];
  logic [15:0] dq_out  [2];
  logic        dq_oe   [2];
  logic [15:0] dq_in   [2];

  always #5 clk = ~clk;

  mem_sram_ctrl #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .MEM_R(mem_r[0]), .MEM_W(mem_w[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]), .freeze(freeze[0]),
    .sram_addr(s_addr[0]), .sram_we_n(we_n[0]), .sram_dq_out(dq_out[0]),
    .sram_dq_oe(dq_oe[0]), .sram_dq_in(dq_in[0])
  );

  mem_sram_ctrl u_dut1 (
    .clk(clk), .rst(rst[1]), .MEM_R(mem_r[1]), .MEM_W(mem_w[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]), .freeze(freeze[1]),
    .sram_addr(s_addr[1]), .sram_we_n(we_n[1]), .sram_dq_out(dq_out[1]),
    .sram_dq_oe(dq_oe[1]), .sram_dq_in(dq_in[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          wc [2] = '{0, 1};
  bit          m_act [2];
  int          m_k   [2];
  bit          m_we  [2];
  logic [16:0] m_ha  [2];
  logic [31:0] m_wd  [2];
  logic [31:0] m_rd  [2];
  logic [15:0] exp_mem [int];
  logic [15:0] env_mem [int];
  logic [17:0] prev_a  [2];
  int          mp, mkey;

  function automatic logic [15:0] exp_rd(input int key);
    return exp_mem.exists(key) ? exp_mem[key] : 16'h0;
  endfunction

  function automatic logic [15:0] env_rd(input int key);
    return env_mem.exists(key) ? env_mem[key] : 16'h0;
  endfunction

  // An access occupies 2*(W+1) phase cycles (k=0..2P-1) and one done cycle (k=2P).
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        mp = wc[i] + 1;
        if (!m_act[i]) begin
          if (mem_r[i] | mem_w[i]) begin
            m_act[i] = 1'b1;
            m_k[i]   = 0;
            m_we[i]  = mem_w[i];
            m_ha[i]  = addr[i][18:2];
            m_wd[i]  = wdata[i];
          end
        end else begin
          if (m_k[i] == 2 * mp) begin
            m_act[i] = 1'b0;
          end else if (m_k[i] == 2 * mp - 1) begin
            mkey = i * (1 << 18) + int'({m_ha[i], 1'b0});
            if (m_we[i]) begin
              exp_mem[mkey]     = m_wd[i][15:0];
              exp_mem[mkey + 1] = m_wd[i][31:16];
            end else begin
              m_rd[i] = {exp_rd(mkey + 1), exp_rd(mkey)};
            end
          end
          m_k[i]++;
        end
      end
    end
  end

  int          cp, ckey;
  bit          clo, chi, cdn;
  logic [17:0] ea;

  // Compare against the model, then act as the SRAM for the next edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst[i]) begin
        m_act[i] = 1'b0;
        m_k[i]   = 0;
        m_rd[i]  = 32'h0;
      end
      cp  = wc[i] + 1;
      clo = m_act[i] && (m_k[i] < cp);
      chi = m_act[i] && (m_k[i] >= cp) && (m_k[i] < 2 * cp);
      cdn = m_act[i] && (m_k[i] == 2 * cp);
      ea  = clo ? {m_ha[i], 1'b0} : (chi ? {m_ha[i], 1'b1} : 18'h0);
      chk($sformatf("u%0d sram_addr", i), 32'(s_addr[i]), 32'(ea));
      chk($sformatf("u%0d we_n", i), 32'(we_n[i]), 32'(!((clo || chi) && m_we[i])));
      chk($sformatf("u%0d dq_oe", i), 32'(dq_oe[i]), 32'((clo || chi) && m_we[i]));
      if ((clo || chi) && m_we[i])
        chk($sformatf("u%0d dq_out", i), 32'(dq_out[i]),
            32'(clo ? m_wd[i][15:0] : m_wd[i][31:16]));
      chk($sformatf("u%0d ready", i), 32'(ready[i]), 32'(cdn));
      chk($sformatf("u%0d freeze", i), 32'(freeze[i]), 32'((mem_r[i] | mem_w[i]) & !cdn));
      chk($sformatf("u%0d rdata", i), rdata[i], m_rd[i]);

      ckey = i * (1 << 18) + int'(s_addr[i]);
      if (!we_n[i] && dq_oe[i]) env_mem[ckey] = dq_out[i];
      // Slow part for the waited instance: data is valid only once the
      // address has been stable for a cycle.
      if (wc[i] == 0 || s_addr[i] == prev_a[i]) dq_in[i] = env_rd(ckey);
      else dq_in[i] = ~env_rd(ckey);
      prev_a[i] = s_addr[i];
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready(input int i, input int lat, input string nm);
    int c;
    bit got;
    got = 1'b0;
    for (c = 0; c < 16; c++) begin
      @(negedge clk);
      if (ready[i]) begin
        got = 1'b1;
        break;
      end
    end
    chk({nm, " latency"}, got ? 32'(c) : 32'hFFFF, 32'(lat));
  endtask

  task automatic access(input int i, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input int lat, input string nm);
    @(posedge clk); #1;
    mem_r[i] = r; mem_w[i] = w; addr[i] = a; wdata[i] = d;
    wait_ready(i, lat, nm);
    @(posedge clk); #1;
    mem_r[i] = 1'b0; mem_w[i] = 1'b0;
  endtask

  logic [17:0] ea1 [6];
  logic [15:0] ed1 [6];
  logic        er1 [6];
  logic [17:0] ea0 [8];
  logic        er0 [8];

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0; mem_r[i] = 1'b0; mem_w[i] = 1'b0;
      addr[i] = '0; wdata[i] = '0; dq_in[i] = '0; prev_a[i] = '0;
      m_act[i] = 1'b0; m_k[i] = 0; m_rd[i] = '0; m_we[i] = 1'b0; m_ha[i] = '0; m_wd[i] = '0;
    end
    #2;
    for (int i = 0; i < 2; i++) begin
      chk("reset rdata", rdata[i], 32'h0);
      chk("reset ready", 32'(ready[i]), 32'h0);
      chk("reset sram_addr", 32'(s_addr[i]), 32'h0);
      chk("reset we_n", 32'(we_n[i]), 32'h1);
      chk("reset dq_out", 32'(dq_out[i]), 32'h0);
      chk("reset dq_oe", 32'(dq_oe[i]), 32'h0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b1; rst[1] = 1'b1;

    // Write 0xDEADBEEF at 0x404, per-cycle literals.
    ea1 = '{18'h0, 18'h202, 18'h202, 18'h203, 18'h203, 18'h0};
    ed1 = '{16'h0, 16'hBEEF, 16'hBEEF, 16'hDEAD, 16'hDEAD, 16'h0};
    er1 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    @(posedge clk); #1;
    mem_w[1] = 1'b1; addr[1] = 32'h0000_0404; wdata[1] = 32'hDEAD_BEEF;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("wr404 c%0d sram_addr", c), 32'(s_addr[1]), 32'(ea1[c]));
      chk($sformatf("wr404 c%0d ready", c), 32'(ready[1]), 32'(er1[c]));
      chk($sformatf("wr404 c%0d freeze", c), 32'(freeze[1]), 32'(!er1[c]));
      if (c >= 1 && c <= 4) begin
        chk($sformatf("wr404 c%0d dq_out", c), 32'(dq_out[1]), 32'(ed1[c]));
        chk($sformatf("wr404 c%0d we_n", c), 32'(we_n[1]), 32'h0);
      end
    end
    @(posedge clk); #1;
    mem_w[1] = 1'b0;

    access(1, 1'b1, 1'b0, 32'h0000_0404, 32'h0, 5, "rd404");
    chk("rd404 rdata", rdata[1], 32'hDEAD_BEEF);

    access(1, 1'b1, 1'b1, 32'h0000_0408, 32'h1234_5678, 5, "rw408");
    chk("rw408 rdata kept", rdata[1], 32'hDEAD_BEEF);
    access(1, 1'b1, 1'b0, 32'h0000_0408, 32'h0, 5, "rd408");
    chk("rd408 rdata", rdata[1], 32'h1234_5678);

    access(1, 1'b1, 1'b0, 32'hFFF8_0405, 32'h0, 5, "rd alias");
    chk("rd alias rdata", rdata[1], 32'hDEAD_BEEF);

    // Inputs change and req drops mid-access: the captured write completes.
    @(posedge clk); #1;
    mem_w[1] = 1'b1; addr[1] = 32'h0000_040C; wdata[1] = 32'hCAFE_F00D;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    mem_w[1] = 1'b0; addr[1] = 32'h0000_0500; wdata[1] = 32'h0;
    wait_ready(1, 3, "wr40c dropped req");
    access(1, 1'b1, 1'b0, 32'h0000_040C, 32'h0, 5, "rd40c");
    chk("rd40c rdata", rdata[1], 32'hCAFE_F00D);

    // Reset during the HI phase of a write, then restart with req held.
    @(posedge clk); #1;
    mem_w[1] = 1'b1; addr[1] = 32'h0000_0410; wdata[1] = 32'h1111_2222;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst[1] = 1'b0;
    #1;
    chk("rst mid-hi we_n", 32'(we_n[1]), 32'h1);
    chk("rst mid-hi sram_addr", 32'(s_addr[1]), 32'h0);
    chk("rst mid-hi dq_oe", 32'(dq_oe[1]), 32'h0);
    chk("rst mid-hi ready", 32'(ready[1]), 32'h0);
    @(posedge clk); #1;
    rst[1] = 1'b1;
    wait_ready(1, 5, "restart");
    @(posedge clk); #1;
    mem_w[1] = 1'b0;
    access(1, 1'b1, 1'b0, 32'h0000_0410, 32'h0, 5, "rd410");
    chk("rd410 rdata", rdata[1], 32'h1111_2222);

    // WAIT_CYCLES=0: back-to-back reads at 0x0 and 0x4 through an IDLE cycle.
    access(0, 1'b0, 1'b1, 32'h0000_0000, 32'hA5A5_0F0F, 3, "w0 wr0");
    access(0, 1'b0, 1'b1, 32'h0000_0004, 32'h0102_0304, 3, "w0 wr4");
    ea0 = '{18'h0, 18'h0, 18'h1, 18'h0, 18'h0, 18'h2, 18'h3, 18'h0};
    er0 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    @(posedge clk); #1;
    mem_r[0] = 1'b1; addr[0] = 32'h0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("b2b c%0d sram_addr", c), 32'(s_addr[0]), 32'(ea0[c]));
      chk($sformatf("b2b c%0d ready", c), 32'(ready[0]), 32'(er0[c]));
      if (c == 3) begin
        chk("b2b rdata0", rdata[0], 32'hA5A5_0F0F);
        @(posedge clk); #1;
        addr[0] = 32'h4;
      end
      if (c == 7) chk("b2b rdata4", rdata[0], 32'h0102_0304);
    end
    @(posedge clk); #1;
    mem_r[0] = 1'b0;

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
